htif_host_master: RTL and testbench

- Host-side initiator for the HTIF host interface of the SodorTile top.
- Turns a simple one-outstanding command port (from a debug loader or bench) into HTIF csr_req/mem_req transactions.
- Collects the matching csr_rep/mem_rep and returns it as a response.
- Sequences the htif reset pulse after power-on and times out hung transactions.

---
 rtl/htif_host_master.sv | 174 +++++++++++++++++
 tb/tb_htif_host_master.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/htif_host_master.sv
// Host-side HTIF initiator: turns a one-outstanding command port into csr/mem request-reply
// transactions, sequences the htif reset pulse and times out hung replies.
module htif_host_master #(
  parameter int unsigned XLEN           = 32,
  parameter int unsigned CSR_ADDR_W     = 12,
  parameter int unsigned MEM_ADDR_W     = 32,
  parameter int unsigned RESET_CYCLES   = 16,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic [1:0]            cmd_op_i,
  input  logic [MEM_ADDR_W-1:0] cmd_addr_i,
  input  logic [XLEN-1:0]       cmd_wdata_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [XLEN-1:0]       rsp_rdata_o,
  output logic                  rsp_err_o,
  output logic                  htif_reset_o,
  output logic                  csr_req_valid_o,
  input  logic                  csr_req_ready_i,
  output logic                  csr_req_rw_o,
  output logic [CSR_ADDR_W-1:0] csr_req_addr_o,
  output logic [XLEN-1:0]       csr_req_data_o,
  input  logic                  csr_rep_valid_i,
  output logic                  csr_rep_ready_o,
  input  logic [XLEN-1:0]       csr_rep_data_i,
  output logic                  mem_req_valid_o,
  input  logic                  mem_req_ready_i,
  output logic                  mem_req_rw_o,
  output logic [MEM_ADDR_W-1:0] mem_req_addr_o,
  output logic [XLEN-1:0]       mem_req_data_o,
  input  logic                  mem_rep_valid_i,
  output logic                  mem_rep_ready_o,
  input  logic [XLEN-1:0]       mem_rep_data_i
);

  localparam int unsigned RstW = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
  localparam int unsigned TmrW = $clog2(TIMEOUT_CYCLES);

  localparam logic [2:0] StRstHold = 3'd0;
  localparam logic [2:0] StIdle    = 3'd1;
  localparam logic [2:0] StReq     = 3'd2;
  localparam logic [2:0] StWaitRep = 3'd3;
  localparam logic [2:0] StResp    = 3'd4;

  logic [2:0]            state_q, state_d;
  logic [RstW-1:0]       rst_cnt_q, rst_cnt_d;
  logic [TmrW-1:0]       timer_q, timer_d;
  logic [1:0]            op_q, op_d;
  logic [MEM_ADDR_W-1:0] addr_q, addr_d;
  logic [XLEN-1:0]       wdata_q, wdata_d;
  logic [XLEN-1:0]       rdata_q, rdata_d;
  logic                  err_q, err_d;
  logic                  drop_csr_q, drop_csr_d;
  logic                  drop_mem_q, drop_mem_d;
  // Low only while rst is asserted, so reply readies stay 0 during reset itself.
  logic                  live_q;

  logic            sel_mem;
  logic            sel_req_ready;
  logic            sel_rep_valid;
  logic            sel_drop;
  logic [XLEN-1:0] sel_rep_data;

  assign sel_mem       = op_q[1];
  assign sel_req_ready = sel_mem ? mem_req_ready_i : csr_req_ready_i;
  assign sel_rep_valid = sel_mem ? mem_rep_valid_i : csr_rep_valid_i;
  assign sel_drop      = sel_mem ? drop_mem_q : drop_csr_q;
  assign sel_rep_data  = sel_mem ? mem_rep_data_i : csr_rep_data_i;

  always_comb begin
    htif_reset_o    = (state_q == StRstHold);
    cmd_ready_o     = (state_q == StIdle);
    rsp_valid_o     = (state_q == StResp);
    rsp_rdata_o     = rdata_q;
    rsp_err_o       = err_q;
    csr_req_valid_o = (state_q == StReq) && !sel_mem;
    mem_req_valid_o = (state_q == StReq) && sel_mem;
    csr_req_rw_o    = op_q[0];
    mem_req_rw_o    = op_q[0];
    csr_req_addr_o  = addr_q[CSR_ADDR_W-1:0];
    mem_req_addr_o  = addr_q;
    csr_req_data_o  = wdata_q;
    mem_req_data_o  = wdata_q;
    csr_rep_ready_o = ((state_q == StRstHold) && live_q) || (state_q == StIdle) ||
                      (state_q == StWaitRep) || ((state_q == StResp) && sel_mem);
    mem_rep_ready_o = ((state_q == StRstHold) && live_q) || (state_q == StIdle) ||
                      (state_q == StWaitRep) || ((state_q == StResp) && !sel_mem);
  end

  always_comb begin
    state_d   = state_q;
    rst_cnt_d = rst_cnt_q;
    timer_d   = timer_q;
    op_d      = op_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    // Any accepted reply settles the reply owed on that channel.
    drop_csr_d = drop_csr_q & ~(csr_rep_valid_i & csr_rep_ready_o);
    drop_mem_d = drop_mem_q & ~(mem_rep_valid_i & mem_rep_ready_o);
    unique case (state_q)
      StRstHold: begin
        if (rst_cnt_q == RstW'(RESET_CYCLES - 1)) state_d = StIdle;
        else rst_cnt_d = rst_cnt_q + 1'b1;
      end
      StIdle: begin
        if (cmd_valid_i) begin
          op_d    = cmd_op_i;
          addr_d  = cmd_addr_i;
          wdata_d = cmd_wdata_i;
          state_d = StReq;
        end
      end
      StReq: begin
        if (sel_req_ready) begin
          timer_d = '0;
          state_d = StWaitRep;
        end
      end
      StWaitRep: begin
        timer_d = timer_q + 1'b1;
        if (sel_rep_valid && !sel_drop) begin
          rdata_d = sel_rep_data;
          err_d   = 1'b0;
          state_d = StResp;
        end else if (timer_q == TmrW'(TIMEOUT_CYCLES - 1)) begin
          rdata_d = '0;
          err_d   = 1'b1;
          state_d = StResp;
          if (sel_mem) drop_mem_d = 1'b1;
          else drop_csr_d = 1'b1;
        end
      end
      StResp: begin
        if (rsp_ready_i) state_d = StIdle;
      end
      default: state_d = StRstHold;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= StRstHold;
      rst_cnt_q  <= '0;
      timer_q    <= '0;
      op_q       <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
      drop_csr_q <= 1'b0;
      drop_mem_q <= 1'b0;
      live_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      rst_cnt_q  <= rst_cnt_d;
      timer_q    <= timer_d;
      op_q       <= op_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      err_q      <= err_d;
      drop_csr_q <= drop_csr_d;
      drop_mem_q <= drop_mem_d;
      live_q     <= 1'b1;
    end
  end

endmodule

// File: tb/tb_htif_host_master.sv
// Bench for htif_host_master: transaction-level model compared every cycle, plus directed
// literal expectations for each scenario.
module tb_htif_host_master;

  localparam int unsigned RC = 16;
  localparam int unsigned TO = 1024;

  logic        clk;
  logic        rst_n;
  logic        cmd_valid, cmd_ready;
  logic [1:0]  cmd_op;
  logic [31:0] cmd_addr, cmd_wdata;
  logic        rsp_valid, rsp_ready, rsp_err, htif_reset;
  logic [31:0] rsp_rdata;
  logic        csr_req_valid, csr_req_ready, csr_req_rw, csr_rep_valid, csr_rep_ready;
  logic [11:0] csr_req_addr;
  logic [31:0] csr_req_data, csr_rep_data;
  logic        mem_req_valid, mem_req_ready, mem_req_rw, mem_rep_valid, mem_rep_ready;
  logic [31:0] mem_req_addr, mem_req_data, mem_rep_data;

  int checks = 0;
  int failures = 0;
  bit cmp_on = 1'b0;

  htif_host_master dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .cmd_valid_i    (cmd_valid),
    .cmd_ready_o    (cmd_ready),
    .cmd_op_i       (cmd_op),
    .cmd_addr_i     (cmd_addr),
    .cmd_wdata_i    (cmd_wdata),
    .rsp_valid_o    (rsp_valid),
    .rsp_ready_i    (rsp_ready),
    .rsp_rdata_o    (rsp_rdata),
    .rsp_err_o      (rsp_err),
    .htif_reset_o   (htif_reset),
    .csr_req_valid_o(csr_req_valid),
    .csr_req_ready_i(csr_req_ready),
    .csr_req_rw_o   (csr_req_rw),
    .csr_req_addr_o (csr_req_addr),
    .csr_req_data_o (csr_req_data),
    .csr_rep_valid_i(csr_rep_valid),
    .csr_rep_ready_o(csr_rep_ready),
    .csr_rep_data_i (csr_rep_data),
    .mem_req_valid_o(mem_req_valid),
    .mem_req_ready_i(mem_req_ready),
    .mem_req_rw_o   (mem_req_rw),
    .mem_req_addr_o (mem_req_addr),
    .mem_req_data_o (mem_req_data),
    .mem_rep_valid_i(mem_rep_valid),
    .mem_rep_ready_o(mem_rep_ready),
    .mem_rep_data_i (mem_rep_data)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Transaction-level model: which command is outstanding, whether its request has been
  // taken, how long the reply has been awaited, and which channels still owe a reply.
  int          m_hold;
  bit          m_live, m_cmd, m_sent, m_rsp, m_err;
  int          m_wait;
  logic [1:0]  m_stale;
  logic [1:0]  m_op;
  logic [31:0] m_addr, m_wdata, m_rdata;

  wire [1:0] rep_v = {mem_rep_valid, csr_rep_valid};
  wire [1:0] req_r = {mem_req_ready, csr_req_ready};

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_hold <= RC; m_live <= 0; m_cmd <= 0; m_sent <= 0; m_rsp <= 0; m_err <= 0;
      m_wait <= 0; m_stale <= '0; m_op <= '0; m_addr <= '0; m_wdata <= '0; m_rdata <= '0;
    end else begin
      m_live <= 1;
      if (m_hold > 0) begin
        m_hold <= m_hold - 1;
      end else if (m_rsp) begin
        if (rep_v[!m_op[1]]) m_stale[!m_op[1]] <= 1'b0;
        if (rsp_ready) m_rsp <= 0;
      end else if (m_cmd && !m_sent) begin
        if (req_r[m_op[1]]) begin m_sent <= 1; m_wait <= 0; end
      end else if (m_cmd) begin
        if (rep_v[!m_op[1]]) m_stale[!m_op[1]] <= 1'b0;
        if (rep_v[m_op[1]] && m_stale[m_op[1]]) m_stale[m_op[1]] <= 1'b0;
        if (rep_v[m_op[1]] && !m_stale[m_op[1]]) begin
          m_rsp <= 1; m_err <= 0; m_cmd <= 0;
          m_rdata <= m_op[1] ? mem_rep_data : csr_rep_data;
        end else if (m_wait == TO - 1) begin
          m_rsp <= 1; m_err <= 1; m_cmd <= 0; m_rdata <= '0; m_stale[m_op[1]] <= 1'b1;
        end
        m_wait <= m_wait + 1;
      end else begin
        if (rep_v[0]) m_stale[0] <= 1'b0;
        if (rep_v[1]) m_stale[1] <= 1'b0;
        if (cmd_valid) begin
          m_cmd <= 1; m_sent <= 0; m_op <= cmd_op; m_addr <= cmd_addr; m_wdata <= cmd_wdata;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_on) begin
      automatic bit e_hold = (m_hold > 0);
      automatic bit e_idle = !e_hold && !m_cmd && !m_rsp;
      automatic bit e_wait = m_cmd && m_sent;
      automatic bit e_csrq = m_cmd && !m_sent && !m_op[1];
      automatic bit e_memq = m_cmd && !m_sent && m_op[1];
      chk("m_htif_reset", htif_reset, e_hold);
      chk("m_cmd_ready", cmd_ready, e_idle);
      chk("m_csr_req_valid", csr_req_valid, e_csrq);
      chk("m_mem_req_valid", mem_req_valid, e_memq);
      chk("m_csr_rep_ready", csr_rep_ready,
          (e_hold && m_live) || e_idle || e_wait || (m_rsp && m_op[1]));
      chk("m_mem_rep_ready", mem_rep_ready,
          (e_hold && m_live) || e_idle || e_wait || (m_rsp && !m_op[1]));
      chk("m_rsp_valid", rsp_valid, m_rsp);
      if (m_rsp || !rst_n) begin
        chk("m_rsp_rdata", rsp_rdata, m_rsp ? m_rdata : 32'h0);
        chk("m_rsp_err", rsp_err, m_rsp ? m_err : 1'b0);
      end
      if (e_csrq) begin
        chk("m_csr_req_rw", csr_req_rw, m_op[0]);
        chk("m_csr_req_addr", csr_req_addr, m_addr[11:0]);
        chk("m_csr_req_data", csr_req_data, m_wdata);
      end
      if (e_memq) begin
        chk("m_mem_req_rw", mem_req_rw, m_op[0]);
        chk("m_mem_req_addr", mem_req_addr, m_addr);
        chk("m_mem_req_data", mem_req_data, m_wdata);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_cmd(input logic [1:0] op, input logic [31:0] a, input logic [31:0] d);
    int n = 0;
    cmd_valid = 1'b1; cmd_op = op; cmd_addr = a; cmd_wdata = d;
    while (!cmd_ready && n < 50) begin tick(); n++; end
    if (!cmd_ready) chk("cmd_accept_bound", 0, 1);
    else tick();
    cmd_valid = 1'b0;
  endtask

  task automatic req_hs(input string name, input bit is_mem, input bit rw,
                        input logic [31:0] a, input int delay);
    chk({name, "_req_latency"}, is_mem ? mem_req_valid : csr_req_valid, 1);
    chk({name, "_req_rw"}, is_mem ? mem_req_rw : csr_req_rw, rw);
    chk({name, "_req_addr"}, is_mem ? mem_req_addr : {20'h0, csr_req_addr}, a);
    for (int i = 0; i < delay; i++) begin
      tick();
      chk({name, "_req_held"}, is_mem ? mem_req_valid : csr_req_valid, 1);
    end
    if (is_mem) mem_req_ready = 1'b1; else csr_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0; csr_req_ready = 1'b0;
  endtask

  task automatic reply(input bit is_mem, input logic [31:0] d);
    int n = 0;
    if (is_mem) begin mem_rep_valid = 1'b1; mem_rep_data = d; end
    else begin csr_rep_valid = 1'b1; csr_rep_data = d; end
    while (!(is_mem ? mem_rep_ready : csr_rep_ready) && n < 50) begin tick(); n++; end
    if (n >= 50) chk("rep_ready_bound", 0, 1);
    tick();
    mem_rep_valid = 1'b0; csr_rep_valid = 1'b0;
  endtask

  task automatic get_rsp(input string name, input logic [31:0] ed, input bit ee,
                         input int hold, input int bound, output int waited);
    waited = 0;
    while (!rsp_valid && waited < bound) begin tick(); waited++; end
    if (!rsp_valid) begin
      chk({name, "_rsp_bound"}, 0, 1);
      return;
    end
    for (int i = 0; i < hold; i++) tick();
    chk({name, "_rdata"}, rsp_rdata, ed);
    chk({name, "_err"}, rsp_err, ee);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk({name, "_rsp_drop"}, rsp_valid, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    rst_n = 1'b0;
    cmd_valid = 0; cmd_op = 0; cmd_addr = 0; cmd_wdata = 0; rsp_ready = 0;
    csr_req_ready = 0; csr_rep_valid = 0; csr_rep_data = 0;
    mem_req_ready = 0; mem_rep_valid = 0; mem_rep_data = 0;
    tick();
    cmp_on = 1'b1;
    tick();
    chk("rst_htif_reset", htif_reset, 1);
    chk("rst_cmd_ready", cmd_ready, 0);
    chk("rst_rep_ready", {csr_rep_ready, mem_rep_ready}, 2'b00);

    // Power-up: htif_reset for exactly RC clocks, cmd_ready rising as it falls.
    rst_n = 1'b1;
    for (int k = 1; k < RC; k++) begin
      tick();
      chk("pwr_htif_hold", htif_reset, 1);
    end
    tick();
    chk("pwr_htif_release", htif_reset, 0);
    chk("pwr_cmd_ready", cmd_ready, 1);

    // CSR write then read, at minimum latency.
    do_cmd(2'b01, 32'h780, 32'hDEADBEEF);
    chk("csrw_req_data", csr_req_data, 32'hDEADBEEF);
    req_hs("csrw", 0, 1, 32'h780, 0);
    reply(0, 32'h0);
    chk("csrw_min_latency", rsp_valid, 1);
    get_rsp("csrw", 32'h0, 0, 0, 10, w);
    do_cmd(2'b00, 32'h780, 32'h0);
    req_hs("csrr", 0, 0, 32'h780, 0);
    reply(0, 32'h12345678);
    get_rsp("csrr", 32'h12345678, 0, 0, 10, w);

    // MEM read with request and response backpressure.
    do_cmd(2'b10, 32'h00002000, 32'h0);
    req_hs("memr", 1, 0, 32'h00002000, 5);
    reply(1, 32'hCAFEF00D);
    get_rsp("memr", 32'hCAFEF00D, 0, 3, 10, w);

    // Timeout, then the late reply to it is discarded.
    do_cmd(2'b10, 32'h00003000, 32'h0);
    req_hs("tmo", 1, 0, 32'h00003000, 0);
    get_rsp("tmo", 32'h0, 1, 0, TO + 50, w);
    chk("tmo_cycles", w, TO);
    do_cmd(2'b10, 32'h00003004, 32'h0);
    req_hs("stale", 1, 0, 32'h00003004, 0);
    reply(1, 32'h1);
    reply(1, 32'h2);
    get_rsp("stale", 32'h2, 0, 0, 10, w);

    // Reply lands in the expiry cycle: it wins.
    do_cmd(2'b11, 32'h00004000, 32'h11112222);
    req_hs("race", 1, 1, 32'h00004000, 0);
    repeat (TO - 1) tick();
    mem_rep_valid = 1'b1; mem_rep_data = 32'h000055AA;
    tick();
    mem_rep_valid = 1'b0;
    get_rsp("race", 32'h000055AA, 0, 0, 5, w);
    chk("race_no_wait", w, 0);

    // Reset while waiting for a reply.
    do_cmd(2'b00, 32'h123, 32'h0);
    req_hs("mrst", 0, 0, 32'h123, 0);
    tick(); tick();
    rst_n = 1'b0;
    #1;
    chk("mrst_htif_reset", htif_reset, 1);
    chk("mrst_valids", {cmd_ready, rsp_valid, csr_req_valid, mem_req_valid}, 4'b0000);
    chk("mrst_rep_ready", {csr_rep_ready, mem_rep_ready}, 2'b00);
    chk("mrst_rdata", rsp_rdata, 32'h0);
    chk("mrst_addr", csr_req_addr, 12'h0);
    tick(); tick();
    rst_n = 1'b1;
    repeat (RC - 1) tick();
    chk("mrst_hold", htif_reset, 1);
    tick();
    chk("mrst_release", {htif_reset, cmd_ready}, 2'b01);
    do_cmd(2'b00, 32'h7C0, 32'h0);
    req_hs("post", 0, 0, 32'h7C0, 0);
    reply(0, 32'hA5A5A5A5);
    get_rsp("post", 32'hA5A5A5A5, 0, 0, 10, w);

    repeat (3) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
